sudoku_board_seeder: RTL and testbench

//  Downstream consumer of the LFSR random-number stage. Builds a fresh 9x9 puzzle on new_game.
//  It loads a canonical solved grid and relabels digits using NUM_SWAPS random digit-pair swaps.
//  It then blanks NUM_BLANKS cells at random positions. It drives gen_rand_flag back to the RNG.
//  The finished board (values + given mask) is presented to the game/display logic.

---
 rtl/sudoku_pkg.sv | 40 ++++
 rtl/rand_sample_req.sv | 67 ++++++
 rtl/sudoku_board_seeder.sv | 241 ++++++++++++++++++++++++
 tb/tb_sudoku_board_seeder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared constants, FSM encoding and canonical grid for the board seeder
// Contents:
//   CELLS/DIGITS, cell and counter widths, seeder_state_t, canonical_grid()
package sudoku_pkg;

    localparam int CELLS   = 81;
    localparam int DIGITS  = 9;
    localparam int CELL_W  = 4;
    localparam int BOARD_W = CELLS * CELL_W;
    localparam int IDX_W   = 7;
    localparam int SWAP_W  = 4;
    localparam int BLANK_W = 7;
    localparam int TRY_W   = 10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_S_REQ,
        ST_S_WAIT,
        ST_S_SCAN,
        ST_B_REQ,
        ST_B_WAIT,
        ST_B_EVAL,
        ST_FIN
    } seeder_state_t;

    // Solved grid: each row is the previous one shifted by 3, with an extra
    // shift of 1 at every band boundary, so rows, columns and boxes all hold 1..9.
    function automatic logic [BOARD_W-1:0] canonical_grid();
        logic [BOARD_W-1:0] g;
        g = '0;
        for (int r = 0; r < DIGITS; r++) begin
            for (int c = 0; c < DIGITS; c++) begin
                g[(r * DIGITS + c) * CELL_W +: CELL_W] = CELL_W'(((3 * r + r / 3 + c) % DIGITS) + 1);
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rand_sample_req.sv
// rtl/rand_sample_req.sv - request pulse and fixed-latency sample handshake with the RNG
// Ports:
//   clka_i          in   clock, state updates on falling edge
//   restart_i       in   asynchronous active-high reset
//   req_i           in   issue a request this cycle
//   wait_i          in   caller is waiting for the random value
//   rand_setup_i    in   RNG setup nibble
//   rand_a_i        in   RNG value A
//   rand_b_i        in   RNG value B
//   gen_rand_flag_o out  request pulse to the RNG
//   sample_o        out  last wait cycle; holding registers load at its end
//   setup_o/a_o/b_o out  held random values
module rand_sample_req #(
    parameter int RAND_WAIT = 2
) (
    input  logic       clka_i,
    input  logic       restart_i,
    input  logic       req_i,
    input  logic       wait_i,
    input  logic [3:0] rand_setup_i,
    input  logic [3:0] rand_a_i,
    input  logic [3:0] rand_b_i,
    output logic       gen_rand_flag_o,
    output logic       sample_o,
    output logic [3:0] setup_o,
    output logic [3:0] a_o,
    output logic [3:0] b_o
);

    localparam int CNT_W = (RAND_WAIT < 2) ? 1 : $clog2(RAND_WAIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       setup_q, a_q, b_q;

    assign gen_rand_flag_o = req_i;
    // RAND_WAIT cycles are spent waiting; the values are captured on the edge
    // that closes the final one.
    assign sample_o = wait_i && ((int'(cnt_q) + 1) >= RAND_WAIT);

    always_comb begin
        cnt_d = '0;
        if (wait_i && !sample_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(negedge clka_i or posedge restart_i) begin
        if (restart_i) begin
            cnt_q   <= '0;
            setup_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (sample_o) begin
                setup_q <= rand_setup_i;
                a_q     <= rand_a_i;
                b_q     <= rand_b_i;
            end
        end
    end

    assign setup_o = setup_q;
    assign a_o     = a_q;
    assign b_o     = b_q;

endmodule

// File: rtl/sudoku_board_seeder.sv
// rtl/sudoku_board_seeder.sv - builds a relabelled, partially blanked 9x9 puzzle from RNG draws
// Ports:
//   clka_i          in   clock, all state updates on falling edge
//   restart_i       in   asynchronous active-high reset
//   new_game_i      in   level; holds generation in LOAD, aborts any run
//   rand_setup_i    in   RNG; bit0 selects symmetric blanking
//   rand_a_i        in   RNG; digit a / blank row
//   rand_b_i        in   RNG; digit b / blank column
//   gen_rand_flag_o out  one-cycle request to the RNG
//   board_vals_o    out  cell i at [4i+3:4i], i = row*9+col
//   given_mask_o    out  1 = cell shown
//   busy_o          out  generation in progress (LOAD..FIN)
//   done_o          out  one-cycle pulse when the board is final
//   err_o           out  request budget exhausted; cleared by new_game
module sudoku_board_seeder
    import sudoku_pkg::*;
#(
    parameter int NUM_SWAPS  = 8,
    parameter int NUM_BLANKS = 45,
    parameter int RAND_WAIT  = 2,
    parameter int MAX_TRIES  = 1023
) (
    input  logic               clka_i,
    input  logic               restart_i,
    input  logic               new_game_i,
    input  logic [3:0]         rand_setup_i,
    input  logic [3:0]         rand_a_i,
    input  logic [3:0]         rand_b_i,
    output logic               gen_rand_flag_o,
    output logic [BOARD_W-1:0] board_vals_o,
    output logic [CELLS-1:0]   given_mask_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam logic [TRY_W-1:0] MAX_T = TRY_W'(MAX_TRIES);

    seeder_state_t state_q, state_d;

    logic [BOARD_W-1:0] vals_q, vals_d;
    logic [CELLS-1:0]   mask_q, mask_d;
    logic [SWAP_W-1:0]  swaps_q, swaps_d;
    logic [BLANK_W-1:0] blanks_q, blanks_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [IDX_W-1:0]   scan_q, scan_d;
    logic               err_q, err_d;

    logic       in_req, in_wait, req_fire, tries_out, sample;
    logic [3:0] setup_s, a_s, b_s;
    logic       unused_setup_bits;

    rand_sample_req #(
        .RAND_WAIT(RAND_WAIT)
    ) u_req (
        .clka_i         (clka_i),
        .restart_i      (restart_i),
        .req_i          (req_fire),
        .wait_i         (in_wait),
        .rand_setup_i   (rand_setup_i),
        .rand_a_i       (rand_a_i),
        .rand_b_i       (rand_b_i),
        .gen_rand_flag_o(gen_rand_flag_o),
        .sample_o       (sample),
        .setup_o        (setup_s),
        .a_o            (a_s),
        .b_o            (b_s)
    );

    assign unused_setup_bits = ^setup_s[3:1];
    assign tries_out = (tries_q == MAX_T);

    // Swap acceptance is judged on the live RNG value on the sampling edge,
    // which is the same value the holding registers capture.
    logic swap_ok;
    assign swap_ok = (rand_a_i >= 4'd1) && (rand_a_i <= 4'd9) &&
                     (rand_b_i >= 4'd1) && (rand_b_i <= 4'd9) &&
                     (rand_a_i != rand_b_i);

    logic swaps_done;
    assign swaps_done = (({1'b0, swaps_q} + 5'd1) == 5'(NUM_SWAPS));

    // Scan: relabel the current cell with the held digit pair.
    logic [CELL_W-1:0] cur_cell, new_cell;
    assign cur_cell = vals_q[int'(scan_q) * CELL_W +: CELL_W];
    always_comb begin
        new_cell = cur_cell;
        if (cur_cell == a_s) begin
            new_cell = b_s;
        end else if (cur_cell == b_s) begin
            new_cell = a_s;
        end
    end

    // Blank evaluation: primary cell, and optionally its point mirror through
    // the centre. The mirror only counts when the primary was freshly cleared.
    logic             blk_valid, prim_hit, mir_hit;
    logic [IDX_W-1:0] blk_idx, mir_idx;
    logic [7:0]       blank_sum;
    logic [BLANK_W-1:0] blank_sat;
    assign blk_valid = (a_s <= 4'd8) && (b_s <= 4'd8);
    assign blk_idx   = {3'b000, a_s} * 7'd9 + {3'b000, b_s};
    assign mir_idx   = 7'(CELLS - 1) - blk_idx;
    assign prim_hit  = blk_valid && mask_q[blk_idx];
    assign mir_hit   = prim_hit && setup_s[0] && (mir_idx != blk_idx) && mask_q[mir_idx];
    assign blank_sum = {1'b0, blanks_q} + {7'b0, prim_hit} + {7'b0, mir_hit};
    assign blank_sat = (blank_sum > 8'(CELLS)) ? BLANK_W'(CELLS) : blank_sum[BLANK_W-1:0];

    // State register
    always_ff @(negedge clka_i or posedge restart_i) begin
        if (restart_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_LOAD: begin
                if (NUM_SWAPS != 0) begin
                    state_d = ST_S_REQ;
                end else if (NUM_BLANKS != 0) begin
                    state_d = ST_B_REQ;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_S_REQ: state_d = tries_out ? ST_FIN : ST_S_WAIT;
            ST_S_WAIT: begin
                if (sample) begin
                    state_d = swap_ok ? ST_S_SCAN : ST_S_REQ;
                end
            end
            ST_S_SCAN: begin
                if (scan_q == IDX_W'(CELLS - 1)) begin
                    if (!swaps_done) begin
                        state_d = ST_S_REQ;
                    end else begin
                        state_d = (NUM_BLANKS != 0) ? ST_B_REQ : ST_FIN;
                    end
                end
            end
            ST_B_REQ: state_d = tries_out ? ST_FIN : ST_B_WAIT;
            ST_B_WAIT: begin
                if (sample) begin
                    state_d = ST_B_EVAL;
                end
            end
            ST_B_EVAL: state_d = (int'(blank_sat) >= NUM_BLANKS) ? ST_FIN : ST_B_REQ;
            ST_FIN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (new_game_i) begin
            state_d = ST_LOAD;
        end
    end

    // Output decode
    always_comb begin
        in_req   = (state_q == ST_S_REQ) || (state_q == ST_B_REQ);
        in_wait  = (state_q == ST_S_WAIT) || (state_q == ST_B_WAIT);
        req_fire = in_req && !tries_out;
        busy_o   = (state_q != ST_IDLE);
        done_o   = (state_q == ST_FIN);
    end

    // Datapath next state
    always_comb begin
        vals_d   = vals_q;
        mask_d   = mask_q;
        swaps_d  = swaps_q;
        blanks_d = blanks_q;
        tries_d  = tries_q;
        scan_d   = scan_q;
        err_d    = err_q;
        if (new_game_i || (state_q == ST_LOAD)) begin
            vals_d   = canonical_grid();
            mask_d   = '1;
            swaps_d  = '0;
            blanks_d = '0;
            tries_d  = '0;
            scan_d   = '0;
            err_d    = 1'b0;
        end else begin
            if (in_req) begin
                if (tries_out) begin
                    err_d = 1'b1;
                end else begin
                    tries_d = tries_q + 1'b1;
                end
            end
            if (state_q == ST_S_SCAN) begin
                vals_d[int'(scan_q) * CELL_W +: CELL_W] = new_cell;
                if (scan_q == IDX_W'(CELLS - 1)) begin
                    scan_d  = '0;
                    swaps_d = swaps_q + 1'b1;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            if (state_q == ST_B_EVAL) begin
                if (prim_hit) begin
                    mask_d[blk_idx] = 1'b0;
                end
                if (mir_hit) begin
                    mask_d[mir_idx] = 1'b0;
                end
                blanks_d = blank_sat;
            end
        end
    end

    always_ff @(negedge clka_i or posedge restart_i) begin
        if (restart_i) begin
            vals_q   <= '0;
            mask_q   <= '0;
            swaps_q  <= '0;
            blanks_q <= '0;
            tries_q  <= '0;
            scan_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            vals_q   <= vals_d;
            mask_q   <= mask_d;
            swaps_q  <= swaps_d;
            blanks_q <= blanks_d;
            tries_q  <= tries_d;
            scan_q   <= scan_d;
            err_q    <= err_d;
        end
    end

    assign board_vals_o = vals_q;
    assign given_mask_o = mask_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_sudoku_board_seeder.sv
// tb/tb_sudoku_board_seeder.sv - self-checking bench for sudoku_board_seeder
module tb_sudoku_board_seeder;

    localparam int NS = 3;
    localparam int NB = 10;
    localparam int RW = 2;
    localparam int MT = 120;

    typedef struct packed {
        logic [3:0] s;
        logic [3:0] a;
        logic [3:0] b;
    } draw_t;

    localparam draw_t STUCK = {4'd0, 4'd15, 4'd15};

    logic         clka = 1'b0;
    logic         restart = 1'b0;
    logic         new_game = 1'b0;
    logic [3:0]   rand_setup = 4'd0;
    logic [3:0]   rand_a = 4'd0;
    logic [3:0]   rand_b = 4'd0;
    logic         gen_rand_flag, busy, done, err;
    logic [323:0] board_vals;
    logic [80:0]  given_mask;

    always #5 clka = ~clka;

    sudoku_board_seeder #(
        .NUM_SWAPS(NS), .NUM_BLANKS(NB), .RAND_WAIT(RW), .MAX_TRIES(MT)
    ) dut (
        .clka_i(clka), .restart_i(restart), .new_game_i(new_game),
        .rand_setup_i(rand_setup), .rand_a_i(rand_a), .rand_b_i(rand_b),
        .gen_rand_flag_o(gen_rand_flag), .board_vals_o(board_vals),
        .given_mask_o(given_mask), .busy_o(busy), .done_o(done), .err_o(err)
    );

    draw_t game_q[$];
    draw_t rng_q[$];
    draw_t nxt;
    int    checks = 0;
    int    passes = 0;
    int    flag_count = 0;
    int    done_count = 0;
    int    consec_viol = 0;
    logic  prev_flag = 1'b0;
    int    exp_grid[81];
    bit    exp_mask[81];

    // RNG stand-in and pulse monitor: each request consumes the next scripted draw.
    always @(posedge clka) begin
        if (gen_rand_flag === 1'b1) begin
            flag_count++;
            if (prev_flag === 1'b1) consec_viol++;
            nxt = (rng_q.size() > 0) ? rng_q.pop_front() : STUCK;
            rand_setup = nxt.s;
            rand_a     = nxt.a;
            rand_b     = nxt.b;
        end
        if (done === 1'b1) done_count++;
        prev_flag = gen_rand_flag;
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    function automatic int canon(input int i);
        int r, c;
        r = i / 9;
        c = i % 9;
        return ((3 * r + r / 3 + c) % 9) + 1;
    endfunction

    function automatic draw_t mk(input int s, input int a, input int b);
        return {4'(s), 4'(a), 4'(b)};
    endfunction

    function automatic draw_t draw_at(input int k);
        if (k < game_q.size()) return game_q[k];
        return STUCK;
    endfunction

    // Reference: relabel the whole grid per accepted pair, then clear cells
    // (and mirrors) until enough blanks exist, within the request budget.
    task automatic model_game(output int reqs, output bit merr);
        int tries, swaps, blanks, k, idx, m;
        draw_t d;
        for (int i = 0; i < 81; i++) begin
            exp_grid[i] = canon(i);
            exp_mask[i] = 1'b1;
        end
        tries = 0; swaps = 0; blanks = 0; k = 0; merr = 1'b0;
        while (swaps < NS && !merr) begin
            if (tries == MT) merr = 1'b1;
            else begin
                d = draw_at(k); k++; tries++;
                if (d.a >= 1 && d.a <= 9 && d.b >= 1 && d.b <= 9 && d.a != d.b) begin
                    for (int i = 0; i < 81; i++) begin
                        if (exp_grid[i] == int'(d.a)) exp_grid[i] = int'(d.b);
                        else if (exp_grid[i] == int'(d.b)) exp_grid[i] = int'(d.a);
                    end
                    swaps++;
                end
            end
        end
        while (NB > 0 && blanks < NB && !merr) begin
            if (tries == MT) merr = 1'b1;
            else begin
                d = draw_at(k); k++; tries++;
                if (d.a <= 8 && d.b <= 8) begin
                    idx = int'(d.a) * 9 + int'(d.b);
                    if (exp_mask[idx]) begin
                        exp_mask[idx] = 1'b0;
                        blanks++;
                        m = 80 - idx;
                        if (d.s[0] && m != idx && exp_mask[m]) begin
                            exp_mask[m] = 1'b0;
                            blanks++;
                        end
                    end
                end
            end
        end
        reqs = tries;
    endtask

    function automatic int board_bad();
        int n = 0;
        for (int i = 0; i < 81; i++) if (board_vals[i*4 +: 4] !== 4'(exp_grid[i])) n++;
        return n;
    endfunction

    function automatic int mask_bad();
        int n = 0;
        for (int i = 0; i < 81; i++) if (given_mask[i] !== exp_mask[i]) n++;
        return n;
    endfunction

    function automatic int canon_bad();
        int n = 0;
        for (int i = 0; i < 81; i++) begin
            if (board_vals[i*4 +: 4] !== 4'(canon(i))) n++;
            if (given_mask[i] !== 1'b1) n++;
        end
        return n;
    endfunction

    task automatic start_game();
        new_game = 1'b1;
        tick(); tick();
    endtask

    task automatic release_game();
        rng_q = game_q;
        flag_count = 0; done_count = 0; consec_viol = 0;
        new_game = 1'b0;
    endtask

    task automatic run_game(input string name);
        int reqs, n;
        bit merr;
        start_game();
        checks++; if (busy !== 1'b1) $display("FAIL %s.load_busy: got %b want 1", name, busy); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL %s.load_err: got %b want 0", name, err); else passes++;
        n = canon_bad();
        checks++; if (n != 0) $display("FAIL %s.load_grid: %0d bad cells want 0", name, n); else passes++;
        release_game();
        model_game(reqs, merr);
        for (int t = 0; t < 20000 && done_count == 0; t++) tick();
        checks++; if (done_count != 1) $display("FAIL %s.done_seen: got %0d pulses want 1", name, done_count); else passes++;
        tick();
        checks++; if ({busy, done} !== 2'b00) $display("FAIL %s.idle_after: got busy/done %b want 00", name, {busy, done}); else passes++;
        checks++; if (flag_count != reqs) $display("FAIL %s.requests: got %0d want %0d", name, flag_count, reqs); else passes++;
        checks++; if (err !== merr) $display("FAIL %s.err: got %b want %b", name, err, merr); else passes++;
        n = board_bad();
        checks++; if (n != 0) $display("FAIL %s.board: %0d bad cells want 0", name, n); else passes++;
        n = mask_bad();
        checks++; if (n != 0) $display("FAIL %s.mask: %0d bad bits want 0", name, n); else passes++;
        repeat (4) tick();
        checks++; if (done_count != 1) $display("FAIL %s.done_once: got %0d want 1", name, done_count); else passes++;
        checks++; if (consec_viol != 0) $display("FAIL %s.flag_b2b: got %0d want 0", name, consec_viol); else passes++;
    endtask

    task automatic test_reset();
        restart = 1'b1;
        #1;
        checks++; if (board_vals !== '0) $display("FAIL reset.board: got %h want 0", board_vals); else passes++;
        checks++; if (given_mask !== '0) $display("FAIL reset.mask: got %h want 0", given_mask); else passes++;
        checks++; if ({busy, done, err, gen_rand_flag} !== 4'b0) $display("FAIL reset.ctrl: got %b want 0000", {busy, done, err, gen_rand_flag}); else passes++;
        tick();
        restart = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0) $display("FAIL reset.idle_busy: got %b want 0", busy); else passes++;
    endtask

    task automatic test_scripted_swap();
        int row0[9] = '{1, 2, 7, 4, 5, 6, 3, 8, 9};
        int n = 0;
        game_q.delete();
        repeat (3) game_q.push_back(mk(0, 3, 7));
        for (int c = 0; c < 9; c++) game_q.push_back(mk(0, 1, c));
        game_q.push_back(mk(0, 2, 0));
        run_game("scripted");
        for (int c = 0; c < 9; c++) if (board_vals[c*4 +: 4] !== 4'(row0[c])) n++;
        checks++; if (n != 0) $display("FAIL scripted.row0: %0d bad cells want 0", n); else passes++;
    endtask

    task automatic test_swap_reject();
        game_q.delete();
        game_q.push_back(mk(0, 0, 5));
        game_q.push_back(mk(0, 9, 9));
        game_q.push_back(mk(0, 12, 3));
        game_q.push_back(mk(0, 2, 4));
        game_q.push_back(mk(0, 5, 6));
        game_q.push_back(mk(0, 1, 9));
        for (int c = 0; c < 9; c++) game_q.push_back(mk(0, 3, c));
        game_q.push_back(mk(0, 4, 0));
        run_game("swap_reject");
    endtask

    task automatic test_blank_mirror();
        game_q.delete();
        repeat (3) game_q.push_back(mk(0, 3, 7));
        game_q.push_back(mk(1, 4, 4));
        game_q.push_back(mk(1, 4, 4));
        game_q.push_back(mk(1, 0, 0));
        game_q.push_back(mk(1, 1, 1));
        game_q.push_back(mk(1, 2, 3));
        game_q.push_back(mk(1, 9, 0));
        game_q.push_back(mk(0, 8, 8));
        game_q.push_back(mk(1, 3, 3));
        game_q.push_back(mk(0, 5, 6));
        run_game("blank_mirror");
        checks++; if ({given_mask[40], given_mask[0], given_mask[80]} !== 3'b000)
            $display("FAIL blank_mirror.cells: got %b want 000", {given_mask[40], given_mask[0], given_mask[80]}); else passes++;
    endtask

    task automatic test_err();
        game_q.delete();
        run_game("stuck_rng");
        repeat (5) tick();
        checks++; if (err !== 1'b1) $display("FAIL stuck_rng.err_sticky: got %b want 1", err); else passes++;
    endtask

    task automatic test_abort_new_game();
        int n;
        game_q.delete();
        repeat (3) game_q.push_back(mk(0, 3, 7));
        for (int c = 0; c < 9; c++) game_q.push_back(mk(0, 5, c));
        game_q.push_back(mk(0, 6, 0));
        start_game();
        release_game();
        for (int t = 0; t < 500 && flag_count < 1; t++) tick();
        checks++; if (flag_count < 1) $display("FAIL abort.first_req: got %0d want 1", flag_count); else passes++;
        repeat (23) tick();
        checks++; if (board_vals[2*4 +: 4] !== 4'd7) $display("FAIL abort.mid_scan: got %0d want 7", board_vals[2*4 +: 4]); else passes++;
        new_game = 1'b1;
        tick();
        n = canon_bad();
        checks++; if (n != 0) $display("FAIL abort.reload: %0d bad cells want 0", n); else passes++;
        checks++; if (done_count != 0) $display("FAIL abort.no_done: got %0d want 0", done_count); else passes++;
        run_game("after_abort");
    endtask

    task automatic test_restart_mid_wait();
        game_q.delete();
        game_q.push_back(mk(0, 3, 7));
        game_q.push_back(mk(0, 1, 2));
        game_q.push_back(mk(0, 4, 5));
        for (int c = 0; c < 9; c++) game_q.push_back(mk(1, 6, c));
        start_game();
        release_game();
        for (int t = 0; t < 2000 && flag_count < 4; t++) tick();
        checks++; if (flag_count < 4) $display("FAIL restart.blank_req: got %0d want 4", flag_count); else passes++;
        tick();
        restart = 1'b1;
        #1;
        checks++; if ({board_vals != '0, given_mask != '0} !== 2'b00) $display("FAIL restart.cleared: got %b want 00", {board_vals != '0, given_mask != '0}); else passes++;
        checks++; if ({busy, done, err, gen_rand_flag} !== 4'b0) $display("FAIL restart.ctrl: got %b want 0000", {busy, done, err, gen_rand_flag}); else passes++;
        repeat (3) tick();
        restart = 1'b0;
        repeat (3) tick();
        checks++; if (done_count != 0) $display("FAIL restart.no_done: got %0d want 0", done_count); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL restart.idle: got %b want 0", busy); else passes++;
    endtask

    task automatic test_random();
        int a, b;
        for (int g = 0; g < 6; g++) begin
            game_q.delete();
            for (int k = 0; k < 150; k++) begin
                a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
                b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
                game_q.push_back(mk(int'($urandom_range(0, 15)), a, b));
            end
            run_game($sformatf("random%0d", g));
        end
    endtask

    initial begin
        test_reset();
        test_scripted_swap();
        test_swap_reject();
        test_blank_mirror();
        test_err();
        test_abort_new_game();
        test_restart_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
